// File: rtl/stp_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : stp_word_collector
// Purpose  : Collects serial words into a flat parallel frame (oldest word in
//            the top slice), closing on NUM_WORDS words or in_last.
//            Optional frame counter enabled by macro STP_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stp_word_collector #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]            out_count,
  output logic [15:0]                 frame_count
);

  localparam int c_idx_w   = $clog2(NUM_WORDS);
  localparam int c_frame_w = NUM_WORDS * WORD_W;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_frame_w-1:0] r_data;
  logic [CNT_W-1:0]     r_count;

  logic                 w_word_xfer;
  logic                 w_frame_xfer;
  logic                 w_last_slot;
  logic [c_frame_w-1:0] w_fill_data;
  logic [c_frame_w-1:0] w_restart_data;

  assign in_ready     = (r_state == FILL) || out_ready;
  assign out_valid    = (r_state == HOLD);
  assign out_data     = r_data;
  assign out_count    = r_count;

  assign w_word_xfer  = in_valid && in_ready;
  assign w_frame_xfer = out_valid && out_ready;
  assign w_last_slot  = (r_idx == c_idx_w'(NUM_WORDS - 1));

  // Word k of the frame lands in slice NUM_WORDS-1-k.
  always_comb begin
    w_fill_data = r_data;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (k == (NUM_WORDS - 1 - int'(r_idx))) begin
        w_fill_data[k*WORD_W +: WORD_W] = in_data;
      end
    end
  end

  // A word accepted during handoff starts a fresh frame in the top slice.
  always_comb begin
    w_restart_data = '0;
    w_restart_data[c_frame_w-1 -: WORD_W] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_word_xfer) begin
            r_data <= w_fill_data;
            if (w_last_slot || in_last) begin
              r_state <= HOLD;
              r_count <= CNT_W'(r_idx) + CNT_W'(1);
              r_idx   <= '0;
            end else begin
              r_idx   <= r_idx + c_idx_w'(1);
            end
          end
        end
        HOLD: begin
          if (w_frame_xfer) begin
            if (w_word_xfer) begin
              r_data <= w_restart_data;
              if (in_last) begin
                r_state <= HOLD;
                r_count <= CNT_W'(1);
                r_idx   <= '0;
              end else begin
                r_state <= FILL;
                r_count <= '0;
                r_idx   <= c_idx_w'(1);
              end
            end else begin
              r_state <= FILL;
              r_data  <= '0;
              r_count <= '0;
              r_idx   <= '0;
            end
          end
        end
        default: begin
          r_state <= FILL;
          r_idx   <= '0;
          r_data  <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

`ifdef STP_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_count <= 16'd0;
    end else if (w_frame_xfer) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stp_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_stp_word_collector
// Purpose  : Directed self-checking bench for stp_word_collector (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stp_word_collector;

  localparam int W  = 32;
  localparam int NW = 8;
  localparam int CW = 4;
`ifdef STP_FRAME_COUNT_EN
  localparam bit c_fc_en = 1'b1;
`else
  localparam bit c_fc_en = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NW*W-1:0] out_data;
  logic [CW-1:0]   out_count;
  logic [15:0]     frame_count;

  int checks   = 0;
  int failures = 0;
  int exp_frames = 0;

  stp_word_collector #(.WORD_W(W), .NUM_WORDS(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count: got %0d required 0", frame_count); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    exp_frames = 0;
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    for (int i = 1; i <= NW; i++) begin
      in_valid = 1'b1; in_data = W'(i); in_last = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid: word %0d got %b required 0", i, out_valid); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid: got %b required 1", out_valid); end
    checks++; if (out_count !== 4'd8) begin failures++; $display("FAIL full_count: got %0d required 8", out_count); end
    checks++; if (out_data[255:224] !== 32'd1) begin failures++; $display("FAIL full_top: got %h required 1", out_data[255:224]); end
    checks++; if (out_data[31:0] !== 32'd8) begin failures++; $display("FAIL full_bottom: got %h required 8", out_data[31:0]); end
    checks++; if (out_data !== {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}) begin
      failures++; $display("FAIL full_data: got %h required 1..8", out_data); end
    tick();
    exp_frames++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_release: got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL full_cleared: got %h required 0", out_data); end
  endtask

  task automatic test_short_frame();
    out_ready = 1'b0;
    in_valid = 1'b0; in_last = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL last_without_valid: got %b required 0", out_valid); end
    in_valid = 1'b1; in_last = 1'b0; in_data = 32'hA1; tick();
    in_data = 32'hB2; tick();
    in_data = 32'hC3; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL short_valid: got %b required 1", out_valid); end
    checks++; if (out_count !== 4'd3) begin failures++; $display("FAIL short_count: got %0d required 3", out_count); end
    checks++; if (out_data !== {32'hA1, 32'hB2, 32'hC3, 160'd0}) begin
      failures++; $display("FAIL short_data: got %h required A1,B2,C3,0...", out_data); end
    out_ready = 1'b1;
    tick();
    exp_frames++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL short_release: got %b required 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [NW*W-1:0] e;
    e = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
    out_ready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + W'(i); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b1; in_data = 32'h99;
    for (int c = 0; c < 10; c++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: cycle %0d got %b required 0", c, in_ready); end
      checks++; if (out_data !== e || out_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold: cycle %0d got v=%b %h required v=1 %h", c, out_valid, out_data, e); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b required 1", in_ready); end
    tick();
    exp_frames++;
    checks++; if (out_valid !== 1'b0 || out_data !== {32'h99, 224'd0}) begin
      failures++; $display("FAIL stall_first_word: got v=%b %h required v=0 top=99", out_valid, out_data); end
    out_ready = 1'b0;
    for (int i = 1; i < NW; i++) begin
      in_data = 32'h99 + W'(i); tick();
    end
    in_valid = 1'b0;
    checks++; if (out_count !== 4'd8 || out_data !== {32'h99, 32'h9A, 32'h9B, 32'h9C, 32'h9D, 32'h9E, 32'h9F, 32'hA0}) begin
      failures++; $display("FAIL stall_no_loss: got cnt=%0d %h required cnt=8 99..A0", out_count, out_data); end
    out_ready = 1'b1;
    tick();
    exp_frames++;
  endtask

  task automatic test_back_to_back();
    logic [NW*W-1:0] e;
    logic [W-1:0]    base;
    out_ready = 1'b1;
    for (int i = 0; i < 2*NW; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + W'(i); in_last = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: word %0d got %b required 1", i, in_ready); end
      tick();
      if (i == NW-1 || i == 2*NW-1) begin
        base = (i == NW-1) ? 32'h100 : 32'h108;
        e = '0;
        for (int k = 0; k < NW; k++) e[(NW-1-k)*W +: W] = base + W'(k);
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin
          failures++; $display("FAIL b2b_frame: word %0d got v=%b %h required v=1 %h", i, out_valid, out_data, e); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: word %0d got %b required 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    tick();
    exp_frames += 2;
  endtask

  task automatic test_handoff_last();
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + W'(i); in_last = 1'b0;
      tick();
    end
    in_data = 32'h2FF; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_count !== 4'd1 || out_data !== {32'h2FF, 224'd0}) begin
      failures++; $display("FAIL handoff_last: got v=%b cnt=%0d %h required v=1 cnt=1 top=2FF", out_valid, out_count, out_data); end
    tick();
    exp_frames += 2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL handoff_last_release: got %b required 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + W'(i); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 4'd0 || frame_count !== 16'd0) begin
      failures++; $display("FAIL midreset_async: got v=%b cnt=%0d fc=%0d %h required all 0", out_valid, out_count, frame_count, out_data); end
    exp_frames = 0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = 32'h400 + W'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_count !== 4'd8 ||
                  out_data !== {32'h400, 32'h401, 32'h402, 32'h403, 32'h404, 32'h405, 32'h406, 32'h407}) begin
      failures++; $display("FAIL midreset_clean: got v=%b cnt=%0d %h required v=1 cnt=8 400..407", out_valid, out_count, out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++; $display("FAIL holdreset: got v=%b %h required v=0 data=0", out_valid, out_data); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame_count();
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = 32'h500 + W'(f); tick();
      in_last = 1'b1; in_data = 32'h600 + W'(f); tick();
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      exp_frames++;
    end
    checks++; if (frame_count !== (c_fc_en ? 16'(exp_frames) : 16'd0)) begin
      failures++; $display("FAIL frame_count: got %0d required %0d", frame_count, c_fc_en ? exp_frames : 0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_stall();
    test_back_to_back();
    test_handoff_last();
    test_mid_reset();
    test_frame_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stp_word_collector.md
STP_WORD_COLLECTOR -- requirements
Module: stp_word_collector

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bit width of one serial word.
REQ-002 SHALL have parameter NUM_WORDS, default 8: words per frame, legal range 2..64.
REQ-003 SHALL have parameter CNT_W, default $clog2(NUM_WORDS+1): width of out_count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid word.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_data  input  WORD_W  serial word.
REQ-009 SHALL have port in_last  input  1  qualified by in_valid; the word ends the frame early.
REQ-010 SHALL have port out_valid  output  1  a completed frame is presented.
REQ-011 SHALL have port out_ready  input  1  consumer takes the frame.
REQ-012 SHALL have port out_data  output  NUM_WORDS*WORD_W  parallel frame, flat packed.
REQ-013 SHALL have port out_count  output  CNT_W  number of valid words in out_data.
REQ-014 SHALL have port frame_count  output  16  completed frames handed off (see Configuration).

Function
REQ-015 A word transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; a frame transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1.
REQ-016 The FSM SHALL have exactly two states, FILL and HOLD. FILL: in_ready=1, out_valid=0. HOLD: out_valid=1, in_ready=out_ready.
REQ-017 In FILL, the k-th accepted word of a frame (k from 0) SHALL be written to slice [(NUM_WORDS-1-k)*WORD_W +: WORD_W], so the oldest word sits in the top slice. This matches the existing shift-register ordering.
REQ-018 FILL SHALL go to HOLD on the cycle the NUM_WORDS-th word is accepted, or on the cycle a word with in_last=1 is accepted, whichever comes first.
- out_valid rises on the next cycle (latency 1 from the last word).
REQ-019 On entry to HOLD, out_count SHALL equal the number of words accepted in the frame (1..NUM_WORDS); slices not written in the frame SHALL read zero.
REQ-020 out_data and out_count SHALL be stable for as long as out_valid=1 and out_ready=0.
REQ-021 When a frame transfer occurs with in_valid=0, the block SHALL return to FILL with the word index at 0 and all slices cleared to zero.
REQ-022 When a frame transfer and a word transfer occur on the same cycle:
- the accepted word SHALL become word 0 of the next frame (zero-bubble back-to-back);
- the remaining slices SHALL be cleared;
- the next state SHALL be FILL;
- if NUM_WORDS were 1-equivalent (in_last=1 on that word), the next state SHALL be HOLD with out_count=1.
REQ-023 in_last=1 on the NUM_WORDS-th word SHALL be treated exactly like a full frame; in_last with in_valid=0 SHALL be ignored.
REQ-024 The internal word index SHALL never exceed NUM_WORDS-1; words SHALL NOT be accepted in HOLD except per REQ-022.

Reset
REQ-025 While rst=1, the block SHALL immediately, and independently of clk, go to state FILL, with:
- word index=0;
- out_data=0, out_count=0, out_valid=0, frame_count=0;
- in_ready=1 from the first clock edge after rst deasserts.
REQ-026 rst asserted mid-frame or in HOLD SHALL discard the partial or pending frame with no transfer reported.

Configuration
REQ-027 With macro STP_FRAME_COUNT_EN defined:
- frame_count SHALL increment by 1 (wrapping at 16'hFFFF -> 0) on every frame transfer.
Without STP_FRAME_COUNT_EN:
- frame_count SHALL be constant 0;
- no counter register SHALL be synthesised.

Verification
REQ-028 Scenario: WORD_W=32, NUM_WORDS=8, feed words 1..8 back-to-back with out_ready=1 -> out_valid one cycle after word 8; out_data top slice=1, bottom slice=8; out_count=8.
REQ-029 Scenario: feed 3 words A,B,C with in_last on C -> out_count=3; top three slices A,B,C; lower five slices 0.
REQ-030 Scenario: hold out_ready=0 for 10 cycles in HOLD while in_valid=1 -> in_ready=0 throughout; out_data unchanged; no word lost once out_ready=1.
REQ-031 Scenario: two frames streamed continuously with out_ready=1 -> the word after frame 1's last is accepted in the handoff cycle; frame 2 is complete 8 cycles later with no gap.
REQ-032 Scenario: assert rst after 5 words -> out_valid=0 and out_data=0 without a clock edge; the next 8 words form a clean frame.
REQ-033 Scenario: with STP_FRAME_COUNT_EN defined, hand off 3 frames -> frame_count=3; without the macro -> frame_count=0.
